shift_arbiter: RTL

- Shares one 16-bit shifter/rotator between two requesters, e.g. the execute-stage ALU and the address/immediate formatting path.
- Each cycle, a round-robin arbiter picks one valid request and drives its operands through the shared combinational shifter.
- The result is pushed into a small in-order output FIFO together with the requester ID.
- The FIFO decouples consumer backpressure, so there is no combinational path from resp_ready to r0_ready/r1_ready.

---
 rtl/shift_arbiter.sv | 111 +++++++++++
 1 files changed

// File: rtl/shift_arbiter.sv
// rtl/shift_arbiter.sv - two-requester round-robin arbiter sharing one 16-bit shifter/rotator, results queued in an in-order FIFO
module shift_arbiter #(
    parameter int DEPTH = 2,
    parameter int PTR_W = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        r0_valid,
    input  logic [15:0] r0_in,
    input  logic [3:0]  r0_cnt,
    input  logic [1:0]  r0_op,
    output logic        r0_ready,
    input  logic        r1_valid,
    input  logic [15:0] r1_in,
    input  logic [3:0]  r1_cnt,
    input  logic [1:0]  r1_op,
    output logic        r1_ready,
    output logic        resp_valid,
    output logic [15:0] resp_out,
    output logic        resp_id,
    input  logic        resp_ready
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    // Rotates take the matching half of the operand doubled up; cnt=0 falls out as a pass-through.
    function automatic logic [15:0] shift_fn(input logic [15:0] x, input logic [3:0] c,
                                             input logic [1:0] op);
        logic [31:0] dbl_l;
        logic [31:0] dbl_r;
        dbl_l = {x, x} << c;
        dbl_r = {x, x} >> c;
        case (op)
            2'b00:   shift_fn = dbl_l[31:16];
            2'b01:   shift_fn = x << c;
            2'b10:   shift_fn = dbl_r[15:0];
            default: shift_fn = x >> c;
        endcase
    endfunction

    logic [PTR_W:0]   count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             prio_q, prio_d;
    logic [16:0]      mem_q [DEPTH];
    logic [16:0]      mem_d [DEPTH];

    logic        full;
    logic        grant0;
    logic        grant1;
    logic        push;
    logic        pop;
    logic        push_id;
    logic [15:0] result;

    always_comb begin
        full     = (count_q == FULL_CNT);
        grant0   = r0_valid && (!r1_valid || !prio_q);
        grant1   = r1_valid && (!r0_valid || prio_q);
        // Ready is also forced low while rst is held so nothing looks accepted during reset.
        r0_ready = grant0 && !full && !rst;
        r1_ready = grant1 && !full && !rst;
        push     = (r0_valid && r0_ready) || (r1_valid && r1_ready);
        push_id  = r1_ready;
        result   = r1_ready ? shift_fn(r1_in, r1_cnt, r1_op) : shift_fn(r0_in, r0_cnt, r0_op);
    end

    always_comb begin
        resp_valid          = (count_q != '0);
        {resp_id, resp_out} = mem_q[rd_ptr_q];
        pop                 = resp_valid && resp_ready;
    end

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        prio_d   = prio_q;
        mem_d    = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = {push_id, result};
            wr_ptr_d        = wr_ptr_q + 1'b1;
            prio_d          = ~push_id;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            prio_q   <= 1'b0;
            mem_q    <= '{default: '0};
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            prio_q   <= prio_d;
            mem_q    <= mem_d;
        end
    end

endmodule
